// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register with next-PC selection, IF/ID
// pipeline register with stall/flush control, and saturating fetch/stall
// performance counters. All outputs come straight from registers.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  input  logic [31:0] Instruction,
  output logic [31:0] PCResult,
  output logic [31:0] IFID_Instruction,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic [31:0] FetchCount,
  output logic [31:0] StallCount
);

  logic [31:0] r_pc;
  logic [31:0] r_ifid_instr;
  logic [31:0] r_ifid_pc4;
  logic        r_ifid_vld;
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_stall_cnt;

  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_redirect;
  logic        w_ifid_load;
  logic        w_stall_cnt_en;

  // Sequential successor wraps modulo 2^32 naturally.
  assign w_pc_plus4     = r_pc + 32'd4;
  assign w_redirect     = Jump | BranchTaken;
  // Normal IF/ID load: neither a bubble nor a hold.
  assign w_ifid_load    = ~Flush & ~Stall;
  // A redirect moves the PC, so that cycle is not a stalled cycle.
  assign w_stall_cnt_en = Stall & ~w_redirect;

  // Next-PC select: jump beats branch, and any redirect beats stall because
  // it comes from an older instruction. Targets are forced word-aligned.
  always_comb begin
    w_next_pc = w_pc_plus4;
    if (Jump)             w_next_pc = {JumpTarget[31:2], 2'b00};
    else if (BranchTaken) w_next_pc = {BranchTarget[31:2], 2'b00};
    else if (Stall)       w_next_pc = r_pc;
  end

  // PC register.
  always_ff @(posedge Clk) begin
    if (Reset) r_pc <= RESET_PC;
    else       r_pc <= w_next_pc;
  end

  // IF/ID register: flush inserts a bubble and wins over stall.
  always_ff @(posedge Clk) begin
    if (Reset || Flush) begin
      r_ifid_instr <= NOP_WORD;
      r_ifid_pc4   <= 32'd0;
      r_ifid_vld   <= 1'b0;
    end else if (!Stall) begin
      r_ifid_instr <= Instruction;
      r_ifid_pc4   <= w_pc_plus4;
      r_ifid_vld   <= 1'b1;
    end
  end

  // Fetch counter: counts normal IF/ID loads, saturating.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_fetch_cnt <= 32'd0;
    else if (w_ifid_load && (r_fetch_cnt != 32'hFFFF_FFFF))
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
  end

  // Stall counter: counts stalled cycles (flush included), saturating.
  always_ff @(posedge Clk) begin
    if (Reset)
      r_stall_cnt <= 32'd0;
    else if (w_stall_cnt_en && (r_stall_cnt != 32'hFFFF_FFFF))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign PCResult         = r_pc;
  assign IFID_Instruction = r_ifid_instr;
  assign IFID_PCPlus4     = r_ifid_pc4;
  assign IFID_Valid       = r_ifid_vld;
  assign FetchCount       = r_fetch_cnt;
  assign StallCount       = r_stall_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: default-reset instance exercises fetch,
// stall, redirect and flush; a second instance covers PC wrap and
// mid-run reset from a high RESET_PC.
module tb_if_stage;

  logic        Clk = 1'b0;
  logic        Reset, Stall, Flush, BranchTaken, Jump;
  logic [31:0] BranchTarget, JumpTarget;
  logic [31:0] Instruction;
  logic [31:0] PCResult, IFID_Instruction, IFID_PCPlus4, FetchCount, StallCount;
  logic        IFID_Valid;

  logic        r1_Reset, r1_Stall;
  logic [31:0] r1_Instruction;
  logic [31:0] r1_PCResult, r1_IFID_Instruction, r1_IFID_PCPlus4, r1_FetchCount, r1_StallCount;
  logic        r1_IFID_Valid;

  logic [31:0] mem [0:1023];
  int npass = 0;
  int ntotal = 0;

  always #5 Clk = ~Clk;

  initial for (int i = 0; i < 1024; i++) mem[i] = i * 3;

  assign Instruction    = mem[PCResult[11:2]];
  assign r1_Instruction = mem[r1_PCResult[11:2]];

  if_stage u_dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .Jump(Jump), .JumpTarget(JumpTarget), .Instruction(Instruction),
    .PCResult(PCResult), .IFID_Instruction(IFID_Instruction),
    .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .FetchCount(FetchCount), .StallCount(StallCount)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFF8)) u_hi (
    .Clk(Clk), .Reset(r1_Reset), .Stall(r1_Stall), .Flush(1'b0),
    .BranchTaken(1'b0), .BranchTarget(32'd0),
    .Jump(1'b0), .JumpTarget(32'd0), .Instruction(r1_Instruction),
    .PCResult(r1_PCResult), .IFID_Instruction(r1_IFID_Instruction),
    .IFID_PCPlus4(r1_IFID_PCPlus4), .IFID_Valid(r1_IFID_Valid),
    .FetchCount(r1_FetchCount), .StallCount(r1_StallCount)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntotal++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_ifid(input string tag, input logic [31:0] ins, input logic [31:0] pc4,
                          input logic vld);
    chk({tag, ".instr"}, IFID_Instruction, ins);
    chk({tag, ".pc4"},   IFID_PCPlus4, pc4);
    chk({tag, ".vld"},   {31'd0, IFID_Valid}, {31'd0, vld});
  endtask

  initial begin
    Reset = 1; Stall = 0; Flush = 0; BranchTaken = 0; Jump = 0;
    BranchTarget = 0; JumpTarget = 0;
    r1_Reset = 1; r1_Stall = 0;

    // Reset state
    step();
    chk("rst.pc", PCResult, 32'h0);
    chk_ifid("rst", 32'h0, 32'h0, 1'b0);
    chk("rst.fetch", FetchCount, 0);
    chk("rst.stall", StallCount, 0);

    // Free-run: 0,3,6,9 with PC+4 of 4,8,12,16
    Reset = 0;
    step(); chk_ifid("run0", 0, 4, 1);  chk("run0.pc", PCResult, 32'h4);
    step(); chk_ifid("run1", 3, 8, 1);
    step(); chk_ifid("run2", 6, 12, 1);
    step(); chk_ifid("run3", 9, 16, 1); chk("run3.pc", PCResult, 32'h10);
    chk("run.fetch", FetchCount, 4);

    // Stall three cycles at PC 0x10
    Stall = 1;
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("stl.pc", PCResult, 32'h10);
      chk_ifid("stl", 9, 16, 1);
      chk("stl.cnt", StallCount, k);
    end
    chk("stl.fetch", FetchCount, 4);
    Stall = 0;
    step(); chk_ifid("stl.rel", 12, 32'h14, 1); chk("stl.rel.fetch", FetchCount, 5);

    // Jump to 0x8, then branch to 0x43 (aligned to 0x40)
    Jump = 1; JumpTarget = 32'h8;
    step(); chk("jmp8.pc", PCResult, 32'h8); chk_ifid("jmp8", 15, 32'h18, 1);
    Jump = 0; BranchTaken = 1; BranchTarget = 32'h43;
    step(); chk("br.pc", PCResult, 32'h40); chk_ifid("br.slot", 6, 32'hC, 1);
    BranchTaken = 0;
    step(); chk_ifid("br.tgt", 48, 32'h44, 1); chk("br.fetch", FetchCount, 8);

    // Jump + branch + stall together: jump wins, IF/ID holds, no stall count
    Jump = 1; JumpTarget = 32'h100; BranchTaken = 1; BranchTarget = 32'h40; Stall = 1;
    step();
    chk("jbs.pc", PCResult, 32'h100);
    chk_ifid("jbs", 48, 32'h44, 1);
    chk("jbs.stall", StallCount, 3);
    chk("jbs.fetch", FetchCount, 8);

    // Move to 0x20, then flush + stall
    BranchTaken = 0; Stall = 0; JumpTarget = 32'h20;
    step(); chk("j20.pc", PCResult, 32'h20); chk_ifid("j20", 192, 32'h104, 1);
    Jump = 0; Flush = 1; Stall = 1;
    step();
    chk("fs.pc", PCResult, 32'h20);
    chk_ifid("fs", 0, 0, 0);
    chk("fs.stall", StallCount, 4);
    chk("fs.fetch", FetchCount, 9);
    Flush = 0; Stall = 0;
    step(); chk_ifid("fs.rel", 24, 32'h24, 1); chk("fs.rel.fetch", FetchCount, 10);

    // Flush alone: bubble while PC advances
    Flush = 1;
    step(); chk_ifid("fl", 0, 0, 0); chk("fl.pc", PCResult, 32'h28);
    chk("fl.fetch", FetchCount, 10);
    Flush = 0;

    // High RESET_PC instance: wrap through zero, then reset mid-run
    r1_Reset = 1;
    step(); chk("hi.rst.pc", r1_PCResult, 32'hFFFF_FFF8); chk("hi.rst.fetch", r1_FetchCount, 0);
    r1_Reset = 0;
    step(); chk("hi.pc1", r1_PCResult, 32'hFFFF_FFFC); chk("hi.pc4a", r1_IFID_PCPlus4, 32'hFFFF_FFFC);
    step(); chk("hi.pc2", r1_PCResult, 32'h0); chk("hi.pc4b", r1_IFID_PCPlus4, 32'h0);
    chk("hi.ins", r1_IFID_Instruction, 32'd3069);
    step(); chk("hi.pc3", r1_PCResult, 32'h4); chk("hi.fetch", r1_FetchCount, 3);
    r1_Stall = 1;
    step(); chk("hi.stl.pc", r1_PCResult, 32'h4); chk("hi.stl.cnt", r1_StallCount, 1);
    r1_Reset = 1;
    step();
    chk("hi.rr.pc", r1_PCResult, 32'hFFFF_FFF8);
    chk("hi.rr.fetch", r1_FetchCount, 0);
    chk("hi.rr.stall", r1_StallCount, 0);
    chk("hi.rr.vld", {31'd0, r1_IFID_Valid}, 32'd0);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS datapath. It owns the program counter, drives the word-aligned fetch address into the instruction memory, and captures the returned instruction into the IF/ID pipeline register. It also performs next-PC selection (sequential / branch / jump), applies stall and flush control from the hazard unit, and keeps fetch and stall performance counters.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_WORD, 32'h0000_0000, instruction word inserted into IF/ID on reset and flush.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- Stall  in  1  hazard unit: hold PC and IF/ID.
- Flush  in  1  hazard unit: load a bubble into IF/ID.
- BranchTaken  in  1  redirect the PC to BranchTarget.
- BranchTarget  in  32  branch destination byte address.
- Jump  in  1  redirect the PC to JumpTarget.
- JumpTarget  in  32  jump destination byte address.
- Instruction  in  32  instruction word returned by the instruction memory for PCResult (combinational, same cycle).
- PCResult  out  32  current PC, driven to the instruction memory address port.
- IFID_Instruction  out  32  registered instruction for decode.
- IFID_PCPlus4  out  32  registered PC+4 of that instruction.
- IFID_Valid  out  1  1 = IF/ID holds a real fetched instruction; 0 = bubble.
- FetchCount  out  32  number of instructions loaded into IF/ID, saturating.
- StallCount  out  32  number of stalled cycles, saturating.

## Operation
- PC register:
  - PCPlus4 = PCResult + 4, modulo 2^32 (0xFFFF_FFFC + 4 = 0x0000_0000).
  - Next-PC priority, highest first:
    1. Reset → RESET_PC.
    2. Jump → {JumpTarget[31:2], 2'b00}.
    3. BranchTaken → {BranchTarget[31:2], 2'b00}.
    4. Stall → hold.
    5. Otherwise → PCPlus4.
  - A redirect overrides Stall, because the redirect comes from an older instruction.
  - Jump has priority over BranchTaken when both are asserted.
- IF/ID register, priority highest first:
  1. Reset → {NOP_WORD, 0, 0} for Instruction, PCPlus4 and Valid respectively.
  2. Flush → {NOP_WORD, 0, 0}. Flush wins over Stall.
  3. Stall → hold all three fields.
  4. Otherwise → {Instruction, PCPlus4, 1}.
- Redirects do not flush IF/ID by themselves; the hazard unit asserts Flush when a squash is required. Branch delay-slot behaviour is therefore the hazard unit's choice.
- FetchCount increments by 1 on every edge where IF/ID takes case 4 (the normal load). It saturates at 0xFFFF_FFFF.
- StallCount increments by 1 on every edge where Stall=1, Reset=0, Jump=0 and BranchTaken=0. It counts even when Flush=1. It saturates at 0xFFFF_FFFF.
- The instruction memory is 1024 words indexed by PCResult[11:2]. PCResult is not masked here; addresses beyond 4 KiB alias in memory.
- Reset values:
  - PCResult = RESET_PC.
  - IFID_Instruction = NOP_WORD.
  - IFID_PCPlus4 = 0.
  - IFID_Valid = 0.
  - FetchCount = 0.
  - StallCount = 0.

## Timing
- All outputs are registered; no output depends combinationally on any input.
- Reset asserted for one edge is sufficient.
- Reset mid-operation overrides every other control on that edge.
- Sequential fetch: PCResult = A in cycle n gives IFID_Instruction = mem[A[11:2]] and IFID_PCPlus4 = A+4 in cycle n+1.
- Redirect asserted in cycle n:
  - PCResult = target in cycle n+1.
  - The target's instruction is in IF/ID in cycle n+2.
  - IF/ID in cycle n+1 holds the instruction fetched in cycle n, unless Flush was also asserted in cycle n.
- Stall for k consecutive cycles (no redirect, no flush):
  - PCResult and IF/ID are unchanged for k edges.
  - StallCount increases by k; FetchCount is unchanged.
- Stall and Flush together: PC holds; IF/ID becomes a bubble; on release, the held PC's instruction loads normally.
- Stall and redirect together: PC takes the target; IF/ID holds (or bubbles if Flush=1).
- Throughput: one instruction per cycle when no control is asserted.

## Test plan
- Reset then free-run with mem[i] = i*3:
  - IFID_Instruction sequence after reset is 0, 3, 6, 9.
  - IFID_PCPlus4 sequence is 4, 8, 12, 16.
  - IFID_Valid is 0 in the first cycle after reset, then 1.
  - FetchCount equals the number of valid loads.
- Stall for 3 cycles at PC = 0x10:
  - PCResult stays 0x10 and IF/ID holds mem[3].
  - StallCount = 3.
  - Release → next IF/ID = mem[4] = 12.
- BranchTaken with target 0x43 at PC = 0x8:
  - Next PCResult = 0x40 (bits [1:0] cleared).
  - The following IF/ID = mem[16] = 48, with IFID_PCPlus4 = 0x44.
- Jump to 0x100 and BranchTaken to 0x40 in the same cycle, with Stall=1:
  - PCResult = 0x100 next cycle.
  - IF/ID holds its previous contents.
  - StallCount is unchanged.
- Flush and Stall together at PC = 0x20:
  - IF/ID = {NOP_WORD, 0, Valid=0} and PCResult stays 0x20.
  - StallCount increases by 1; FetchCount is unchanged.
  - Release → IF/ID = mem[8] = 24.
- RESET_PC = 0xFFFF_FFF8, free-run:
  - PCResult sequence is 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
  - Asserting Reset mid-run returns PCResult to 0xFFFF_FFF8 and clears both counters on the next edge.
